// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
//   DATA_BITS            : payload bits per frame
//   DEFAULT_CLKS_PER_BIT : clk cycles per bit; matches the receiver oversample rate
//   tx_state_t           : transmitter FSM states
package uart_pkg;

   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 16;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

endpackage

// File: rtl/uart_transmitter_if.sv
// Host-side byte handshake into the UART transmitter.
//   tx_data       : byte to send (host -> tx)
//   tx_data_valid : host offers tx_data (host -> tx)
//   tx_ready      : holding buffer empty (tx -> host)
// A byte transfers on a clk edge where tx_data_valid & tx_ready.
interface uart_transmitter_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_data_valid;
   logic                 tx_ready;

   modport master (output tx_data, output tx_data_valid, input tx_ready);
   modport slave  (input tx_data, input tx_data_valid, output tx_ready);

endinterface

// File: rtl/uart_transmitter_counter.sv
// Generic up-counter with synchronous load.
//   clk  : clock
//   rst  : synchronous active-high reset, clears q
//   load : q <= d (priority over en)
//   en   : q <= q + 1
//   d    : load value
//   q    : count
module uart_transmitter_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (en) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-byte holding buffer so frames can go out
// back-to-back with no idle gap.
//   clk       : sole clock
//   rst       : synchronous reset, active-high
//   host      : byte handshake (tx_data, tx_data_valid, tx_ready)
//   tx_serial : registered UART line, idle high
//   busy      : a frame is being shifted
//   tx_done   : one-cycle pulse on the last cycle of the final stop bit
//
// state | meaning
// IDLE  | line high, waiting for the holding buffer to fill
// START | driving the start bit (low)
// DATA  | driving data bits, LSB first
// STOP  | driving STOP_BITS stop bits (high)
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic                clk,
   input  logic                rst,
   uart_transmitter_if.slave   host,
   output logic                tx_serial,
   output logic                busy,
   output logic                tx_done
);

   localparam int              BW        = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);
   localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

   tx_state_t            cs;
   tx_state_t            ns;
   logic [BW-1:0]        baud_cnt;
   logic [2:0]           bit_cnt;
   logic                 bit_end;
   logic                 last_stop;
   logic                 baud_load;
   logic                 bit_load;
   logic                 load_shift;
   logic                 accept;
   logic                 buf_full;
   logic [DATA_BITS-1:0] buf_data;
   logic [DATA_BITS-1:0] shifter;
   logic                 tx_serial_nxt;

   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign last_stop = (bit_cnt == STOP_LAST);
   assign accept    = host.tx_data_valid & ~buf_full;
   assign host.tx_ready = ~buf_full;
   assign busy      = (cs != IDLE);

   // Baud counter is parked at 0 in IDLE and wraps on every bit boundary.
   assign baud_load = (cs == IDLE) | bit_end;

   // Bit counter indexes data bits in DATA; the 3-bit wrap from 7 to 0 on the
   // last data bit lets the same counter number the stop bits in STOP.
   assign bit_load  = (cs == IDLE) | (cs == START);

   uart_transmitter_counter #(.WIDTH(BW)) u_baud_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (baud_load),
      .en   (1'b1),
      .d    ('0),
      .q    (baud_cnt)
   );

   uart_transmitter_counter #(.WIDTH(3)) u_bit_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (bit_load),
      .en   (bit_end),
      .d    ('0),
      .q    (bit_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cs <= IDLE;
      end else begin
         cs <= ns;
      end
   end

   always_comb begin
      ns            = cs;
      tx_serial_nxt = tx_serial;
      load_shift    = 1'b0;
      tx_done       = 1'b0;
      case (cs)
         IDLE: begin
            if (buf_full) begin
               ns            = START;
               load_shift    = 1'b1;
               tx_serial_nxt = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               ns            = DATA;
               tx_serial_nxt = shifter[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt == BIT_LAST) begin
                  ns            = STOP;
                  tx_serial_nxt = 1'b1;
               end else begin
                  // shifter[0] is the bit on the line now; [1] goes out next.
                  tx_serial_nxt = shifter[1];
               end
            end
         end
         STOP: begin
            if (bit_end && last_stop) begin
               tx_done = 1'b1;
               if (buf_full) begin
                  ns            = START;
                  load_shift    = 1'b1;
                  tx_serial_nxt = 1'b0;
               end else begin
                  ns = IDLE;
               end
            end
         end
         default: ns = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_serial <= 1'b1;
         buf_full  <= 1'b0;
         buf_data  <= '0;
         shifter   <= '0;
      end else begin
         tx_serial <= tx_serial_nxt;
         // A new byte wins over the load so the buffer stays full with it.
         if (accept) begin
            buf_full <= 1'b1;
            buf_data <= host.tx_data;
         end else if (load_shift) begin
            buf_full <= 1'b0;
         end
         if (load_shift) begin
            shifter <= buf_data;
         end else if ((cs == DATA) && bit_end) begin
            shifter <= shifter >> 1;
         end
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: two instances (16 clk/bit with 1 stop bit,
// 4 clk/bit with 2 stop bits), a frame-position model checked every cycle,
// a line decoder acting as the loopback receiver, and directed tests.
module tb_uart_transmitter;

   localparam int CPB_A = 16;
   localparam int SB_A  = 1;
   localparam int CPB_B = 4;
   localparam int SB_B  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_transmitter_if if_a ();
   uart_transmitter_if if_b ();

   logic tx_a, busy_a, done_a;
   logic tx_b, busy_b, done_b;

   uart_transmitter #(.CLKS_PER_BIT(CPB_A), .STOP_BITS(SB_A)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .host      (if_a),
      .tx_serial (tx_a),
      .busy      (busy_a),
      .tx_done   (done_a)
   );

   uart_transmitter #(.CLKS_PER_BIT(CPB_B), .STOP_BITS(SB_B)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .host      (if_b),
      .tx_serial (tx_b),
      .busy      (busy_b),
      .tx_done   (done_b)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each frame is a position counter 0..(9+stop)*cpb-1; the line level
   // follows from which bit period the position falls in.
   bit         m_buf [2];
   bit         m_act [2];
   bit         m_acc [2];
   int         m_pos [2];
   logic [7:0] m_byte[2];
   logic [7:0] m_frame[2];

   task automatic model_step(int i, bit r, bit v, logic [7:0] d, int cpb, int sb);
      int fl;
      bit start;
      fl = (9 + sb) * cpb;
      m_acc[i] = 1'b0;
      if (r) begin
         m_buf[i] = 1'b0;
         m_act[i] = 1'b0;
         m_pos[i] = 0;
         return;
      end
      start = m_buf[i] && (!m_act[i] || m_pos[i] == fl - 1);
      if (m_act[i]) begin
         if (m_pos[i] == fl - 1) m_act[i] = 1'b0;
         else m_pos[i]++;
      end
      if (start) begin
         m_act[i]   = 1'b1;
         m_pos[i]   = 0;
         m_frame[i] = m_byte[i];
      end
      if (v && !m_buf[i]) begin
         m_buf[i]  = 1'b1;
         m_byte[i] = d;
         m_acc[i]  = 1'b1;
      end else if (start) begin
         m_buf[i] = 1'b0;
      end
   endtask

   function automatic logic exp_line(int i, int cpb);
      int b;
      if (!m_act[i]) return 1'b1;
      b = m_pos[i] / cpb;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_frame[i][b-1];
      return 1'b1;
   endfunction

   function automatic logic exp_done(int i, int cpb, int sb);
      return m_act[i] && (m_pos[i] == (9 + sb) * cpb - 1);
   endfunction

   always @(posedge clk) begin
      cyc++;
      model_step(0, rst, if_a.tx_data_valid, if_a.tx_data, CPB_A, SB_A);
      model_step(1, rst, if_b.tx_data_valid, if_b.tx_data, CPB_B, SB_B);
   end

   always @(negedge clk) begin
      check("a_tx_serial", tx_a, exp_line(0, CPB_A));
      check("a_tx_ready", if_a.tx_ready, !m_buf[0]);
      check("a_busy", busy_a, m_act[0]);
      check("a_tx_done", done_a, exp_done(0, CPB_A, SB_A));
      check("b_tx_serial", tx_b, exp_line(1, CPB_B));
      check("b_tx_ready", if_b.tx_ready, !m_buf[1]);
      check("b_busy", busy_b, m_act[1]);
      check("b_tx_done", done_b, exp_done(1, CPB_B, SB_B));
      if (done_a === 1'b1) done_cnt_a++;
      if (done_b === 1'b1) done_cnt_b++;
   end

   // ---------------- loopback receiver on tx_a ----------------
   logic [7:0] rx_q[$];
   bit         rx_check = 1'b1;

   initial begin
      logic [7:0] v;
      forever begin
         @(negedge clk);
         if (!rst && tx_a === 1'b0) begin
            repeat (CPB_A / 2 - 1) @(negedge clk);
            if (tx_a === 1'b0) begin
               for (int b = 0; b < 8; b++) begin
                  repeat (CPB_A) @(negedge clk);
                  v[b] = tx_a;
               end
               repeat (CPB_A) @(negedge clk);
               if (rx_check) check("rx_framing", tx_a, 1'b1);
               rx_q.push_back(v);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic nclk();
      @(negedge clk);
      #1;
   endtask

   task automatic send(int i, logic [7:0] d);
      int t;
      t = 0;
      if (i == 0) begin
         if_a.tx_data_valid = 1'b1;
         if_a.tx_data       = d;
      end else begin
         if_b.tx_data_valid = 1'b1;
         if_b.tx_data       = d;
      end
      do begin
         nclk();
         t++;
      end while (!m_acc[i] && t < 2000);
      if (!m_acc[i]) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: byte %0h not accepted within %0d cycles", d, t);
      end
   endtask

   task automatic idle(int i);
      if (i == 0) if_a.tx_data_valid = 1'b0;
      else if_b.tx_data_valid = 1'b0;
   endtask

   task automatic wait_cyc(int c);
      while (cyc < c) nclk();
   endtask

   // ---------------- directed tests ----------------
   bit exp_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
   logic [7:0] loop_bytes[4] = '{8'h00, 8'h55, 8'hAA, 8'hFF};
   logic [7:0] bp_bytes[3]   = '{8'h11, 8'h22, 8'h33};

   initial begin
      int k, k1, k2, k3, d0, busy_low, stop_hi;
      if_a.tx_data_valid = 1'b0;
      if_a.tx_data       = 8'h00;
      if_b.tx_data_valid = 1'b0;
      if_b.tx_data       = 8'h00;

      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         if_a.tx_data_valid = 1'($urandom_range(0, 1));
         if_a.tx_data       = 8'($urandom);
         if_b.tx_data_valid = 1'($urandom_range(0, 1));
         if_b.tx_data       = 8'($urandom);
         nclk();
      end
      check("rst_tx_serial", tx_a, 1'b1);
      check("rst_tx_ready", if_a.tx_ready, 1'b1);
      check("rst_busy", busy_a, 1'b0);
      check("rst_tx_done", done_a, 1'b0);
      rst = 1'b0;
      idle(0);
      idle(1);
      repeat (20) nclk();
      check("post_rst_idle_line", tx_a, 1'b1);
      check("post_rst_idle_busy", busy_a, 1'b0);

      // Single byte 0xA5
      rx_q.delete();
      d0 = done_cnt_a;
      send(0, 8'hA5);
      k = cyc;
      idle(0);
      check("a5_ready_low_after_accept", if_a.tx_ready, 1'b0);
      check("a5_line_high_at_accept", tx_a, 1'b1);
      wait_cyc(k + 1);
      check("a5_start_first_cycle", tx_a, 1'b0);
      wait_cyc(k + 9);
      check("a5_start_mid", tx_a, 1'b0);
      for (int b = 0; b < 8; b++) begin
         repeat (CPB_A) nclk();
         check("a5_data_bit", tx_a, exp_a5[b]);
      end
      repeat (CPB_A) nclk();
      check("a5_stop", tx_a, 1'b1);
      wait_cyc(k + 160);
      check("a5_done_cycle160", done_a, 1'b1);
      check("a5_done_count", done_cnt_a - d0, 1);
      nclk();
      check("a5_done_cleared", done_a, 1'b0);
      check("a5_busy_cleared", busy_a, 1'b0);
      repeat (10) nclk();
      check("a5_rx_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check("a5_rx_byte", rx_q[0], 8'hA5);

      // Back-to-back 0x00 then 0xFF
      rx_q.delete();
      d0 = done_cnt_a;
      busy_low = 0;
      send(0, 8'h00);
      k = cyc;
      send(0, 8'hFF);
      idle(0);
      while (cyc < k + 321) begin
         nclk();
         if (cyc >= k + 1 && cyc <= k + 320 && busy_a !== 1'b1) busy_low++;
         if (cyc == k + 160) begin
            check("b2b_first_done", done_a, 1'b1);
            check("b2b_stop_high", tx_a, 1'b1);
         end
         if (cyc == k + 161) check("b2b_second_start_no_gap", tx_a, 1'b0);
      end
      check("b2b_busy_low_cycles", busy_low, 0);
      check("b2b_done_count", done_cnt_a - d0, 2);
      repeat (10) nclk();
      check("b2b_rx_count", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         check("b2b_rx_0", rx_q[0], 8'h00);
         check("b2b_rx_1", rx_q[1], 8'hFF);
      end

      // Backpressure 0x11, 0x22, 0x33 with valid held high
      rx_q.delete();
      send(0, 8'h11);
      k1 = cyc;
      send(0, 8'h22);
      k2 = cyc;
      check("bp_ready_low_with_22", if_a.tx_ready, 1'b0);
      check("bp_22_accept_delay", k2 - k1, 2);
      send(0, 8'h33);
      k3 = cyc;
      idle(0);
      check("bp_33_accept_delay", k3 - k1, 162);
      repeat (3 * 160 + 20) nclk();
      check("bp_rx_count", rx_q.size(), 3);
      if (rx_q.size() == 3) begin
         for (int i = 0; i < 3; i++) check("bp_rx_byte", rx_q[i], bp_bytes[i]);
      end

      // Instance B: 4 clk/bit, 2 stop bits, 0x80 followed by a buffered byte
      d0 = done_cnt_b;
      stop_hi = 0;
      send(1, 8'h80);
      k = cyc;
      send(1, 8'h01);
      idle(1);
      while (cyc < k + 45) begin
         nclk();
         if (cyc >= k + 37 && cyc <= k + 44 && tx_b === 1'b1) stop_hi++;
         if (cyc == k + 1)  check("sb2_start", tx_b, 1'b0);
         if (cyc == k + 32) check("sb2_bit6", tx_b, 1'b0);
         if (cyc == k + 36) check("sb2_bit7", tx_b, 1'b1);
         if (cyc == k + 44) check("sb2_done_cycle44", done_b, 1'b1);
         if (cyc == k + 45) check("sb2_next_start", tx_b, 1'b0);
      end
      check("sb2_stop_high_cycles", stop_hi, 8);
      check("sb2_done_count", done_cnt_b - d0, 1);
      repeat (60) nclk();
      check("sb2_idle_after", busy_b, 1'b0);

      // Reset mid-DATA of 0x3C with another byte buffered
      d0 = done_cnt_a;
      send(0, 8'h3C);
      k = cyc;
      idle(0);
      wait_cyc(k + 50);
      send(0, 8'h99);
      idle(0);
      rx_check = 1'b0;
      rst = 1'b1;
      nclk();
      check("midrst_tx_serial", tx_a, 1'b1);
      check("midrst_tx_ready", if_a.tx_ready, 1'b1);
      check("midrst_busy", busy_a, 1'b0);
      check("midrst_tx_done", done_a, 1'b0);
      rst = 1'b0;
      repeat (200) nclk();
      check("midrst_no_done", done_cnt_a - d0, 0);
      check("midrst_line_idle", tx_a, 1'b1);
      rx_q.delete();
      rx_check = 1'b1;

      // Loopback of four bytes
      foreach (loop_bytes[i]) send(0, loop_bytes[i]);
      idle(0);
      repeat (4 * 160 + 40) nclk();
      check("loop_rx_count", rx_q.size(), 4);
      if (rx_q.size() == 4) begin
         for (int i = 0; i < 4; i++) check("loop_rx_byte", rx_q[i], loop_bytes[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
